// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: FSM state encoding,
// operation codes and default build parameters.
package md_pkg;

    localparam int unsigned STATE_W       = 3;
    localparam int unsigned ITERS_DEFAULT = 16;
    localparam int unsigned CNT_W_DEFAULT = 4;

    // Sequencer states
    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_FIN  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    // Operation select as seen by the datapath (dp_op_div)
    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/multdiv_iter_ctr.sv
// Iteration counter for the multiply/divide sequencer.
// Ports:
//   clk_i    clock, rising edge
//   rst_ni   asynchronous reset, active-low
//   clr_i    synchronous clear (priority over enable)
//   en_i     advance one step; wraps to 0 after ITERS-1
//   count_o  registered step index 0..ITERS-1
//   tc_c_o   combinational terminal count: last step and enabled
module multdiv_iter_ctr #(
    parameter int unsigned ITERS = 16,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output logic             tc_c_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             last_c;

    assign last_c = (count_q == CNT_W'(ITERS - 1));

    // Next count: clear wins, otherwise step with explicit wrap at ITERS-1
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = last_c ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_c_o  = last_c & en_i;

endmodule

// File: rtl/multdiv_sequencer.sv
// Control FSM for the iterative multiply/divide datapath.
// Sequences LOAD -> RUN (ITERS steps) -> FIN -> DONE per start pulse; a new
// start in any state aborts and restarts; divide-by-zero short-cuts to DONE.
// Ports:
//   clock, reset_n        clock (rising edge), async active-low reset
//   ctrl_MULT, ctrl_DIV   one-cycle start pulses (multiply has priority)
//   div_by_zero           divisor==0 flag, sampled with ctrl_DIV
//   mult_ovf              product overflow flag, sampled in FIN
//   dp_load/step/finalize datapath phase strobes
//   dp_op_div             0 = multiply, 1 = divide
//   iter_count            current step index
//   busy                  LOAD through FIN
//   data_resultRDY        one-cycle result-valid pulse
//   data_exception        exception flag, qualified by data_resultRDY
module multdiv_sequencer
    import md_pkg::*;
#(
    parameter int unsigned ITERS = ITERS_DEFAULT,
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             div_by_zero,
    input  logic             mult_ovf,
    output logic             dp_load,
    output logic             dp_step,
    output logic             dp_finalize,
    output logic             dp_op_div,
    output logic [CNT_W-1:0] iter_count,
    output logic             busy,
    output logic             data_resultRDY,
    output logic             data_exception
);

    state_e state_q;
    state_e state_d;
    logic   op_q;
    logic   op_d;
    logic   exc_q;
    logic   exc_d;
    logic   dp_load_q;
    logic   dp_step_q;
    logic   dp_fin_q;
    logic   busy_q;
    logic   rdy_q;
    logic   cnt_clr_c;
    logic   cnt_en_c;
    logic   cnt_tc_c;

    // Counter is zeroed on every entry into LOAD so a restart begins at step 0
    assign cnt_clr_c = (state_d == S_LOAD);
    assign cnt_en_c  = (state_q == S_RUN);

    multdiv_iter_ctr #(
        .ITERS (ITERS),
        .CNT_W (CNT_W)
    ) u_iter_ctr (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .clr_i   (cnt_clr_c),
        .en_i    (cnt_en_c),
        .count_o (iter_count),
        .tc_c_o  (cnt_tc_c)
    );

    // Next state, operation and exception; start pulses override any state
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        exc_d   = exc_q;
        if (ctrl_MULT) begin
            state_d = S_LOAD;
            op_d    = OP_MULT;
        end else if (ctrl_DIV) begin
            op_d = OP_DIV;
            if (div_by_zero) begin
                state_d = S_DONE;
                exc_d   = 1'b1;
            end else begin
                state_d = S_LOAD;
            end
        end else begin
            case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_LOAD: state_d = S_RUN;
                S_RUN:  state_d = cnt_tc_c ? S_FIN : S_RUN;
                S_FIN: begin
                    state_d = S_DONE;
                    exc_d   = (op_q == OP_MULT) & mult_ovf;
                end
                S_DONE: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State plus Moore outputs registered from the next state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            op_q      <= OP_MULT;
            exc_q     <= 1'b0;
            dp_load_q <= 1'b0;
            dp_step_q <= 1'b0;
            dp_fin_q  <= 1'b0;
            busy_q    <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            exc_q     <= exc_d;
            dp_load_q <= (state_d == S_LOAD);
            dp_step_q <= (state_d == S_RUN);
            dp_fin_q  <= (state_d == S_FIN);
            busy_q    <= (state_d == S_LOAD) || (state_d == S_RUN) || (state_d == S_FIN);
            rdy_q     <= (state_d == S_DONE);
        end
    end

    assign dp_load        = dp_load_q;
    assign dp_step        = dp_step_q;
    assign dp_finalize    = dp_fin_q;
    assign dp_op_div      = op_q;
    assign busy           = busy_q;
    assign data_resultRDY = rdy_q;
    assign data_exception = exc_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed testbench for multdiv_sequencer: default build (ITERS=16) plus an
// ITERS=1 build sharing the same stimulus.
module tb_multdiv_sequencer;

    logic       clock;
    logic       reset_n;
    logic       ctrl_MULT;
    logic       ctrl_DIV;
    logic       div_by_zero;
    logic       mult_ovf;

    logic       a_load, a_step, a_fin, a_opdiv, a_busy, a_rdy, a_exc;
    logic [3:0] a_cnt;
    logic       b_load, b_step, b_fin, b_opdiv, b_busy, b_rdy, b_exc;
    logic [0:0] b_cnt;

    int checks;
    int failures;

    multdiv_sequencer #(.ITERS(16), .CNT_W(4)) dut_a (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .div_by_zero    (div_by_zero),
        .mult_ovf       (mult_ovf),
        .dp_load        (a_load),
        .dp_step        (a_step),
        .dp_finalize    (a_fin),
        .dp_op_div      (a_opdiv),
        .iter_count     (a_cnt),
        .busy           (a_busy),
        .data_resultRDY (a_rdy),
        .data_exception (a_exc)
    );

    multdiv_sequencer #(.ITERS(1), .CNT_W(1)) dut_b (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .div_by_zero    (div_by_zero),
        .mult_ovf       (mult_ovf),
        .dp_load        (b_load),
        .dp_step        (b_step),
        .dp_finalize    (b_fin),
        .dp_op_div      (b_opdiv),
        .iter_count     (b_cnt),
        .busy           (b_busy),
        .data_resultRDY (b_rdy),
        .data_exception (b_exc)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] outs;
        reset_n = 1'b0; ctrl_MULT = 0; ctrl_DIV = 0; div_by_zero = 0; mult_ovf = 0;
        repeat (3) tick();
        outs = {a_load, a_step, a_fin, a_opdiv, a_busy, a_rdy, a_exc, |a_cnt};
        checks++;
        if (outs !== 8'h00) begin
            failures++;
            $display("FAIL reset_initial_a: got %b expected 00000000", outs);
        end
        outs = {b_load, b_step, b_fin, b_opdiv, b_busy, b_rdy, b_exc, b_cnt[0]};
        checks++;
        if (outs !== 8'h00) begin
            failures++;
            $display("FAIL reset_initial_b: got %b expected 00000000", outs);
        end
        reset_n = 1'b1;
        tick();
        // Start a multiply and reset it mid-RUN
        ctrl_MULT = 1'b1;
        tick();
        ctrl_MULT = 1'b0;
        repeat (8) tick();
        checks++;
        if (a_cnt !== 4'd7 || a_step !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre_count: got cnt=%0d step=%b expected cnt=7 step=1", a_cnt, a_step);
        end
        #2 reset_n = 1'b0;
        #1;
        outs = {a_load, a_step, a_fin, a_opdiv, a_busy, a_rdy, a_exc, |a_cnt};
        checks++;
        if (outs !== 8'h00) begin
            failures++;
            $display("FAIL reset_async: got %b expected 00000000", outs);
        end
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (a_busy !== 1'b0 || a_load !== 1'b0 || a_rdy !== 1'b0 || a_cnt !== 4'd0) begin
                failures++;
                $display("FAIL reset_idle_after: cyc=%0d got busy=%b load=%b rdy=%b cnt=%0d expected all 0",
                         k, a_busy, a_load, a_rdy, a_cnt);
            end
        end
    endtask

    // Full multiply (or divide when is_div) with given overflow flag in FIN
    task automatic test_operation(input logic is_div, input logic ovf, input logic exp_exc);
        if (is_div) ctrl_DIV = 1'b1; else ctrl_MULT = 1'b1;
        tick();
        ctrl_DIV = 1'b0; ctrl_MULT = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            logic exp_load, exp_step, exp_fin, exp_rdy, exp_busy;
            exp_load = (k == 1);
            exp_step = (k >= 2 && k <= 17);
            exp_fin  = (k == 18);
            exp_rdy  = (k == 19);
            exp_busy = (k >= 1 && k <= 18);
            checks++;
            if ({a_load, a_step, a_fin, a_rdy, a_busy} !== {exp_load, exp_step, exp_fin, exp_rdy, exp_busy}) begin
                failures++;
                $display("FAIL op_phase div=%b k=%0d: got ld/st/fn/rdy/busy=%b expected %b", is_div, k,
                         {a_load, a_step, a_fin, a_rdy, a_busy},
                         {exp_load, exp_step, exp_fin, exp_rdy, exp_busy});
            end
            checks++;
            if (a_opdiv !== is_div) begin
                failures++;
                $display("FAIL op_div k=%0d: got %b expected %b", k, a_opdiv, is_div);
            end
            if (exp_step) begin
                checks++;
                if (a_cnt !== 4'(k - 2)) begin
                    failures++;
                    $display("FAIL op_iter_count k=%0d: got %0d expected %0d", k, a_cnt, k - 2);
                end
            end
            if (k >= 19) begin
                checks++;
                if (a_exc !== exp_exc) begin
                    failures++;
                    $display("FAIL op_exception div=%b k=%0d: got %b expected %b", is_div, k, a_exc, exp_exc);
                end
            end
            mult_ovf = (k == 18) ? ovf : 1'b0;
            tick();
        end
        mult_ovf = 1'b0;
    endtask

    task automatic test_multiply();
        test_operation(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_mult_overflow();
        test_operation(1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_divide();
        // Overflow flag must be ignored for a divide
        test_operation(1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_div_by_zero();
        ctrl_DIV = 1'b1; div_by_zero = 1'b1;
        tick();
        ctrl_DIV = 1'b0; div_by_zero = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (a_rdy !== (k == 1) || a_exc !== 1'b1 || a_load !== 1'b0 || a_step !== 1'b0 ||
                a_busy !== 1'b0 || a_opdiv !== 1'b1) begin
                failures++;
                $display("FAIL div_by_zero k=%0d: got rdy=%b exc=%b load=%b step=%b busy=%b op=%b expected rdy=%b exc=1 load=0 step=0 busy=0 op=1",
                         k, a_rdy, a_exc, a_load, a_step, a_busy, a_opdiv, (k == 1));
            end
            tick();
        end
    endtask

    task automatic test_restart();
        ctrl_MULT = 1'b1;
        tick();
        ctrl_MULT = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            if (k == 9) begin
                checks++;
                if (a_cnt !== 4'd7) begin
                    failures++;
                    $display("FAIL restart_pre_count: got %0d expected 7", a_cnt);
                end
            end
            if (k == 10) begin
                checks++;
                if (a_load !== 1'b1 || a_opdiv !== 1'b1 || a_cnt !== 4'd0 || a_step !== 1'b0) begin
                    failures++;
                    $display("FAIL restart_load: got load=%b op=%b cnt=%0d step=%b expected load=1 op=1 cnt=0 step=0",
                             a_load, a_opdiv, a_cnt, a_step);
                end
            end
            checks++;
            if (a_rdy !== (k == 28)) begin
                failures++;
                $display("FAIL restart_rdy k=%0d: got %b expected %b", k, a_rdy, (k == 28));
            end
            ctrl_DIV = (k == 9);
            tick();
        end
        ctrl_DIV = 1'b0;
    endtask

    task automatic test_simultaneous();
        // div_by_zero also high: the dropped divide must not short-cut to DONE
        ctrl_MULT = 1'b1; ctrl_DIV = 1'b1; div_by_zero = 1'b1;
        tick();
        ctrl_MULT = 1'b0; ctrl_DIV = 1'b0; div_by_zero = 1'b0;
        for (int k = 1; k <= 21; k++) begin
            if (k == 1) begin
                checks++;
                if (a_opdiv !== 1'b0 || a_load !== 1'b1 || b_opdiv !== 1'b0) begin
                    failures++;
                    $display("FAIL simul_start: got op_a=%b load_a=%b op_b=%b expected 0 1 0", a_opdiv, a_load, b_opdiv);
                end
            end
            checks++;
            if (a_rdy !== (k == 19)) begin
                failures++;
                $display("FAIL simul_rdy_a k=%0d: got %b expected %b", k, a_rdy, (k == 19));
            end
            checks++;
            if (b_rdy !== (k == 4) || b_busy !== (k >= 1 && k <= 3)) begin
                failures++;
                $display("FAIL iters1_b k=%0d: got rdy=%b busy=%b expected rdy=%b busy=%b",
                         k, b_rdy, b_busy, (k == 4), (k >= 1 && k <= 3));
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        ctrl_MULT = 1'b1;
        tick();
        ctrl_MULT = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            checks++;
            if (a_rdy !== (k == 19 || k == 38) || a_load !== (k == 1 || k == 20)) begin
                failures++;
                $display("FAIL back_to_back k=%0d: got rdy=%b load=%b expected rdy=%b load=%b",
                         k, a_rdy, a_load, (k == 19 || k == 38), (k == 1 || k == 20));
            end
            ctrl_MULT = (k == 19);
            tick();
        end
        ctrl_MULT = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n = 1'b0; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0; div_by_zero = 1'b0; mult_ovf = 1'b0;
        test_reset();
        test_multiply();
        test_mult_overflow();
        test_divide();
        test_div_by_zero();
        test_restart();
        test_simultaneous();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
